// File: rtl/speck_decrypt_core.sv
// Speck inverse-round engine (Speck128/128 by default).
// A key load runs the forward key schedule into a small round-key RAM. Each
// ciphertext pair then takes one inverse round per clock, using the round keys
// from last to first. The plaintext pair is held until the consumer takes it.
module speck_decrypt_core #(
    parameter int WORD   = 64,
    parameter int ROUNDS = 32,
    parameter int ALPHA  = 8,
    parameter int BETA   = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            key_ld,
    input  logic [WORD-1:0] key_k0,
    input  logic [WORD-1:0] key_l0,
    output logic            key_ready,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [WORD-1:0] ct_x,
    input  logic [WORD-1:0] ct_y,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [WORD-1:0] pt_x,
    output logic [WORD-1:0] pt_y
);

    localparam int CW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        KEYEXP = 2'd1,
        DEC    = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t          state_reg;
    logic [WORD-1:0] k_reg;
    logic [WORD-1:0] l_reg;
    logic [WORD-1:0] x_reg;
    logic [WORD-1:0] y_reg;
    logic [CW-1:0]   i_reg;
    logic [CW-1:0]   r_reg;
    logic            key_ready_reg;
    logic            out_valid_reg;

    // Round-key storage; read asynchronously so every round completes in one cycle
    logic [WORD-1:0] rk_mem [ROUNDS];

    // Key-schedule datapath
    logic [WORD-1:0] exp_ror_l;
    logic [WORD-1:0] exp_rol_k;
    logic [WORD-1:0] exp_l_next;
    logic [WORD-1:0] exp_k_next;

    // Inverse-round datapath
    logic [WORD-1:0] dec_key;
    logic [WORD-1:0] dec_xy;
    logic [WORD-1:0] dec_y_next;
    logic [WORD-1:0] dec_diff;
    logic [WORD-1:0] dec_x_next;

    // RAM write port
    logic            rk_we;
    logic [CW-1:0]   rk_waddr;
    logic [WORD-1:0] rk_wdata;

    // Constant rotates are pure wiring: one bit-select per output bit
    genvar gi;
    generate
        for (gi = 0; gi < WORD; gi++) begin : g_rot
            assign exp_ror_l[gi]  = l_reg[(gi + ALPHA) % WORD];
            assign exp_rol_k[gi]  = k_reg[(gi + WORD - BETA) % WORD];
            assign dec_y_next[gi] = dec_xy[(gi + BETA) % WORD];
            assign dec_x_next[gi] = dec_diff[(gi + WORD - ALPHA) % WORD];
        end
    endgenerate

    // Forward schedule step: l' = (k + ROR(l)) ^ i, k' = ROL(k) ^ l'
    assign exp_l_next = (k_reg + exp_ror_l) ^ WORD'(i_reg);
    assign exp_k_next = exp_rol_k ^ exp_l_next;

    // Inverse round: y' = ROR(x ^ y), x' = ROL((x ^ k) - y')
    assign dec_key  = rk_mem[r_reg];
    assign dec_xy   = x_reg ^ y_reg;
    assign dec_diff = (x_reg ^ dec_key) - dec_y_next;

    // rk[0] is written on the load cycle itself, rk[i+1] on each expansion cycle
    assign rk_we    = ((state_reg == IDLE) && key_ld) || (state_reg == KEYEXP);
    assign rk_waddr = (state_reg == IDLE) ? '0 : i_reg + CW'(1);
    assign rk_wdata = (state_reg == IDLE) ? key_k0 : exp_k_next;

    // Round-key RAM write; contents are not reset
    always_ff @(posedge clk) begin
        if (rk_we) begin
            rk_mem[rk_waddr] <= rk_wdata;
        end
    end

    // Control FSM with the key-schedule and cipher state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            k_reg         <= '0;
            l_reg         <= '0;
            x_reg         <= '0;
            y_reg         <= '0;
            i_reg         <= '0;
            r_reg         <= '0;
            key_ready_reg <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (key_ld) begin
                        // A key load wins over a ciphertext offered in the same cycle
                        k_reg         <= key_k0;
                        l_reg         <= key_l0;
                        i_reg         <= '0;
                        key_ready_reg <= 1'b0;
                        state_reg     <= KEYEXP;
                    end else if (in_valid && key_ready_reg) begin
                        x_reg     <= ct_x;
                        y_reg     <= ct_y;
                        r_reg     <= CW'(ROUNDS - 1);
                        state_reg <= DEC;
                    end
                end
                KEYEXP: begin
                    k_reg <= exp_k_next;
                    l_reg <= exp_l_next;
                    i_reg <= i_reg + CW'(1);
                    if (i_reg == CW'(ROUNDS - 2)) begin
                        key_ready_reg <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                DEC: begin
                    x_reg <= dec_x_next;
                    y_reg <= dec_y_next;
                    r_reg <= r_reg - CW'(1);
                    if (r_reg == '0) begin
                        out_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign key_ready = key_ready_reg;
    assign in_ready  = (state_reg == IDLE) && key_ready_reg && !key_ld;
    assign out_valid = out_valid_reg;
    assign pt_x      = x_reg;
    assign pt_y      = y_reg;

endmodule

// File: tb/tb_speck_decrypt_core.sv
// Testbench for speck_decrypt_core: known-answer, handshake, collision and
// abort cases, plus random plaintexts encrypted by a forward Speck model.
module tb_speck_decrypt_core;

    localparam int WORD   = 64;
    localparam int ROUNDS = 32;
    localparam int ALPHA  = 8;
    localparam int BETA   = 3;

    localparam logic [63:0] KAT_K0 = 64'h0706050403020100;
    localparam logic [63:0] KAT_L0 = 64'h0f0e0d0c0b0a0908;
    localparam logic [127:0] KAT_CT = {64'ha65d985179783265, 64'h7860fedf5c570d18};
    localparam logic [127:0] KAT_PT = {64'h6c61766975716520, 64'h7469206564616d20};

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        key_ld = 1'b0;
    logic [63:0] key_k0 = '0;
    logic [63:0] key_l0 = '0;
    logic        key_ready;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] ct_x = '0;
    logic [63:0] ct_y = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] pt_x;
    logic [63:0] pt_y;

    int checks = 0;
    int failures = 0;
    bit bp_mode = 1'b0;

    logic [127:0] exp_q [$];
    logic [127:0] mon_exp;
    logic [63:0]  rk_model [ROUNDS];

    speck_decrypt_core #(
        .WORD(WORD), .ROUNDS(ROUNDS), .ALPHA(ALPHA), .BETA(BETA)
    ) dut (
        .clk(clk), .reset(reset),
        .key_ld(key_ld), .key_k0(key_k0), .key_l0(key_l0), .key_ready(key_ready),
        .in_valid(in_valid), .in_ready(in_ready), .ct_x(ct_x), .ct_y(ct_y),
        .out_valid(out_valid), .out_ready(out_ready), .pt_x(pt_x), .pt_y(pt_y)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [63:0] ror(input logic [63:0] v, input int s);
        return (v >> s) | (v << (64 - s));
    endfunction

    function automatic logic [63:0] rol(input logic [63:0] v, input int s);
        return (v << s) | (v >> (64 - s));
    endfunction

    // Software Speck key schedule
    task automatic model_key(input logic [63:0] k0, input logic [63:0] l0);
        logic [63:0] k;
        logic [63:0] l;
        k = k0;
        l = l0;
        rk_model[0] = k;
        for (int i = 0; i < ROUNDS - 1; i++) begin
            l = (k + ror(l, ALPHA)) ^ 64'(i);
            k = rol(k, BETA) ^ l;
            rk_model[i + 1] = k;
        end
    endtask

    // Software Speck forward encryption of {x,y}
    function automatic logic [127:0] model_enc(input logic [127:0] pt);
        logic [63:0] x;
        logic [63:0] y;
        x = pt[127:64];
        y = pt[63:0];
        for (int i = 0; i < ROUNDS; i++) begin
            x = (ror(x, ALPHA) + y) ^ rk_model[i];
            y = rol(y, BETA) ^ x;
        end
        return {x, y};
    endfunction

    // Monitor: every output handshake pops and compares one expected plaintext
    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output actual=%h required=none", {pt_x, pt_y});
            end else begin
                mon_exp = exp_q.pop_front();
                check("pt", {pt_x, pt_y}, mon_exp);
                $display("out pt=%h", {pt_x, pt_y});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_in_ready();
        int n;
        n = 0;
        while (!in_ready && n < 300) begin
            if (bp_mode) out_ready = 1'($urandom_range(0, 1));
            step();
            n++;
        end
        check("in_ready_wait", 128'(in_ready), 128'(1));
    endtask

    task automatic load_key(input logic [63:0] k, input logic [63:0] l, input bit with_ct);
        int n;
        key_k0 = k;
        key_l0 = l;
        key_ld = 1'b1;
        if (with_ct) begin
            in_valid = 1'b1;
            ct_x = {$urandom, $urandom};
            ct_y = {$urandom, $urandom};
            #1;
            check("in_ready_during_key_ld", 128'(in_ready), 128'(0));
        end
        step();
        key_ld = 1'b0;
        in_valid = 1'b0;
        check("key_ready_drop", 128'(key_ready), 128'(0));
        for (n = 1; n <= 100; n++) begin
            step();
            if (key_ready) break;
        end
        check("keyexp_cycles", 128'(n), 128'(ROUNDS - 1));
        check("in_ready_after_key", 128'(in_ready), 128'(1));
        check("no_out_after_key", 128'(out_valid), 128'(0));
        model_key(k, l);
        $display("key k0=%h l0=%h exp_cycles=%0d", k, l, n);
    endtask

    // Issue one ciphertext, measure latency; ld_at>0 pulses key_ld that many edges in
    task automatic decrypt(input logic [127:0] ct, input logic [127:0] pt, input int ld_at);
        int n;
        wait_in_ready();
        ct_x = ct[127:64];
        ct_y = ct[63:0];
        in_valid = 1'b1;
        exp_q.push_back(pt);
        step();
        in_valid = 1'b0;
        ct_x = {$urandom, $urandom};
        ct_y = {$urandom, $urandom};
        for (n = 1; n <= 100; n++) begin
            key_ld = (n == ld_at);
            if (key_ld) begin
                key_k0 = {$urandom, $urandom};
                key_l0 = {$urandom, $urandom};
            end
            if (bp_mode) out_ready = 1'($urandom_range(0, 1));
            step();
            key_ld = 1'b0;
            if (out_valid) break;
        end
        check("latency", 128'(n), 128'(ROUNDS));
        if (ld_at > 0) check("key_ready_after_dec_key_ld", 128'(key_ready), 128'(1));
        $display("in ct=%h latency=%0d", ct, n);
    endtask

    initial begin
        logic [127:0] pt;
        bit saw;

        // T1: reset state
        step();
        step();
        check("rst_key_ready", 128'(key_ready), 128'(0));
        check("rst_in_ready", 128'(in_ready), 128'(0));
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_pt", {pt_x, pt_y}, 128'(0));
        reset = 1'b1;
        step();

        // Reference model known answer
        model_key(KAT_K0, KAT_L0);
        check("model_kat", model_enc(KAT_PT), KAT_CT);

        // T2 / T3
        load_key(KAT_K0, KAT_L0, 1'b0);
        decrypt(KAT_CT, KAT_PT, 0);

        // T5a: key_ld during DEC is ignored
        decrypt(KAT_CT, KAT_PT, 5);

        // T4: backpressure in DONE
        wait_in_ready();
        out_ready = 1'b0;
        decrypt(KAT_CT, KAT_PT, 0);
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1;
            ct_x = {$urandom, $urandom};
            ct_y = {$urandom, $urandom};
            step();
            check("bp_pt", {pt_x, pt_y}, KAT_PT);
            check("bp_in_ready", 128'(in_ready), 128'(0));
            check("bp_out_valid", 128'(out_valid), 128'(1));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        check("bp_release_out_valid", 128'(out_valid), 128'(0));
        check("bp_release_in_ready", 128'(in_ready), 128'(1));
        decrypt(KAT_CT, KAT_PT, 0);

        // T5b: key_ld with in_valid in IDLE
        wait_in_ready();
        load_key(KAT_K0, KAT_L0, 1'b1);
        decrypt(KAT_CT, KAT_PT, 0);

        // T6: reset mid-DEC
        wait_in_ready();
        ct_x = KAT_CT[127:64];
        ct_y = KAT_CT[63:0];
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (16) step();
        reset = 1'b0;
        #1;
        check("abort_key_ready", 128'(key_ready), 128'(0));
        check("abort_in_ready", 128'(in_ready), 128'(0));
        check("abort_out_valid", 128'(out_valid), 128'(0));
        check("abort_pt", {pt_x, pt_y}, 128'(0));
        step();
        step();
        reset = 1'b1;
        saw = 1'b0;
        for (int c = 0; c < 50; c++) begin
            step();
            if (out_valid) saw = 1'b1;
        end
        check("abort_no_output", 128'(saw), 128'(0));
        check("abort_key_ready_held", 128'(key_ready), 128'(0));
        $display("abort done");

        load_key(KAT_K0, KAT_L0, 1'b0);
        decrypt(KAT_CT, KAT_PT, 0);

        // Random plaintexts under the reference key, second half with random backpressure
        for (int v = 0; v < 800; v++) begin
            bp_mode = (v >= 400);
            pt = {$urandom, $urandom, $urandom, $urandom};
            decrypt(model_enc(pt), pt, 0);
        end

        // Random key, random plaintexts
        wait_in_ready();
        bp_mode = 1'b0;
        out_ready = 1'b1;
        load_key({$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
        for (int v = 0; v < 200; v++) begin
            pt = {$urandom, $urandom, $urandom, $urandom};
            decrypt(model_enc(pt), pt, 0);
        end

        for (int c = 0; c < 200; c++) begin
            if (exp_q.size() == 0) break;
            step();
        end
        check("queue_drained", 128'(exp_q.size()), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
